// File: rtl/updown_sweep_pkg.sv
// Shared types for the up/down sweep controller.
package updown_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UP,
    DOWN
  } sweep_state_t;

endpackage

// File: rtl/updown_sweep_ctrl.sv
// Drives an up_down_counter through a programmable lo..hi triangle sweep,
// counting completed periods and watching the counter for out-of-range values.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  lo,
  input  logic [N-1:0]  hi,
  input  logic [SW-1:0] sweeps,
  input  logic [N-1:0]  ctr_q,
  output logic          ctr_en_b,
  output logic          ctr_load_b,
  output logic          ctr_up,
  output logic [N-1:0]  ctr_load_in,
  output logic          busy,
  output logic [SW-1:0] sweeps_done,
  output logic          done,
  output logic          cfg_err,
  output logic          fault
);

  sweep_state_t  state_q, state_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [SW-1:0] sweeps_q, sweeps_d;
  logic [SW-1:0] sweeps_done_q, sweeps_done_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          fault_q, fault_d;

  logic          at_lo;
  logic          at_hi;
  logic          in_rng;
  logic [SW-1:0] sd_inc;

  assign at_lo  = (ctr_q == lo_q);
  assign at_hi  = (ctr_q == hi_q);
  assign in_rng = (ctr_q >= lo_q) && (ctr_q <= hi_q);
  // saturating period count
  assign sd_inc = (&sweeps_done_q) ? sweeps_done_q
                                   : sweeps_done_q + SW'(1);

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    sweeps_d      = sweeps_q;
    sweeps_done_d = sweeps_done_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    fault_d       = 1'b0;
    ctr_en_b      = 1'b1;
    ctr_load_b    = 1'b1;
    ctr_up        = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (lo < hi) begin
            lo_d          = lo;
            hi_d          = hi;
            sweeps_d      = sweeps;
            sweeps_done_d = '0;
            state_d       = LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          ctr_load_b = 1'b0;
          state_d    = UP;
        end
      end
      UP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!in_rng) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          // turn on the peak edge so hi is not repeated
          ctr_en_b = 1'b0;
          ctr_up   = !at_hi;
          if (at_hi) state_d = DOWN;
        end
      end
      DOWN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!in_rng) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else if (!at_lo) begin
          ctr_en_b = 1'b0;
          ctr_up   = 1'b0;
        end else begin
          sweeps_done_d = sd_inc;
          if ((sweeps_q != '0) && (sd_inc == sweeps_q)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ctr_en_b = 1'b0;
            ctr_up   = 1'b1;
            state_d  = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      sweeps_q      <= '0;
      sweeps_done_q <= '0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      sweeps_q      <= sweeps_d;
      sweeps_done_q <= sweeps_done_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      fault_q       <= fault_d;
    end
  end

  assign ctr_load_in = lo_q;
  assign busy        = (state_q != IDLE);
  assign sweeps_done = sweeps_done_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign fault       = fault_q;

endmodule
